// File: rtl/fw_pkg.sv
// Shared types and widths for the firewall transaction arbiter.
package fw_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned DATA_W = 32;

   // Arbiter sequencing: grant, present to filter, read verdict, then forward or drop.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      EVAL  = 3'd2,
      FWD   = 3'd3,
      DROP  = 3'd4
   } state_t;

   // One bus transaction as seen by the filter and the downstream port.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] data;
   } txn_t;

endpackage

// File: rtl/fw_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module fw_rr_arbiter #(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IDX_W-1:0]   idx_c,
   output logic               any_c
);

   logic [IDX_W-1:0] cand;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
         if (!any_c && req[cand]) begin
            grant_c[cand] = 1'b1;
            idx_c         = cand;
            any_c         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fw_txn_arbiter.sv
// Shares one packet filter between NUM_REQ requesters; forwards clean txns,
// drops and counts violating ones, and locks out repeat offenders.
module fw_txn_arbiter
   import fw_pkg::*;
#(
   parameter int unsigned  NUM_REQ     = 4,
   parameter int unsigned  LOCK_THRESH = 3,
   parameter int unsigned  CNT_W       = 16,
   localparam int unsigned SRC_W       = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [ADDR_W-1:0]         flt_addr,
   output logic [CMD_W-1:0]          flt_cmd,
   output logic [DATA_W-1:0]         flt_data,
   input  logic                      flt_violation,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_W-1:0]         out_addr,
   output logic [CMD_W-1:0]          out_cmd,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
   output logic                      drop_pulse,
   output logic [NUM_REQ-1:0]        lock_status,
   input  logic [NUM_REQ-1:0]        unlock,
   output logic [CNT_W-1:0]          viol_total
);

   // Per-requester violation counter width; threshold never exceeds 15.
   localparam int unsigned LCNT_W = 4;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   rr_ptr_q, src_q, out_src_q, rr_idx, next_ptr;
   logic [NUM_REQ-1:0] eligible, rr_grant, lock_q;
   logic               rr_any, out_valid_q, drop_q;
   txn_t               req_txn [NUM_REQ];
   txn_t               grant_txn, txn_q, flt_q, out_q;
   logic [LCNT_W-1:0]  viol_cnt_q [NUM_REQ];
   logic [CNT_W-1:0]   total_q;

   // Split the flat request buses into per-requester transactions.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_txn[i] = {req_addr[ADDR_W*i +: ADDR_W],
                           req_cmd[CMD_W*i +: CMD_W],
                           req_data[DATA_W*i +: DATA_W]};
   end

   assign eligible  = req_valid & ~lock_q;
   assign grant_txn = req_txn[rr_idx];
   assign next_ptr  = SRC_W'((32'(rr_idx) + 32'd1) % NUM_REQ);

   fw_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req     (eligible),
      .ptr     (rr_ptr_q),
      .grant_c (rr_grant),
      .idx_c   (rr_idx),
      .any_c   (rr_any)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and the same-cycle accept pulse to the granted requester.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               state_d   = ISSUE;
               req_ready = rr_grant;
            end
         end
         ISSUE:   state_d = EVAL;
         EVAL:    state_d = flt_violation ? DROP : FWD;
         FWD:     if (out_ready) state_d = IDLE;
         DROP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Txn latch, filter drive, downstream port, drop pulse and total count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         src_q       <= '0;
         txn_q       <= '0;
         flt_q       <= '0;
         out_q       <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         total_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rr_any) begin
                  txn_q    <= grant_txn;
                  flt_q    <= grant_txn;
                  src_q    <= rr_idx;
                  rr_ptr_q <= next_ptr;
               end
            end
            EVAL: begin
               flt_q     <= '0;
               out_src_q <= src_q;
               if (flt_violation) begin
                  drop_q <= 1'b1;
               end else begin
                  out_valid_q <= 1'b1;
                  out_q       <= txn_q;
               end
            end
            FWD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_q       <= '0;
               end
            end
            DROP: begin
               drop_q <= 1'b0;
               if (total_q != '1) total_q <= total_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Per-requester violation counts and lockout; software unlock wins over a drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) viol_cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (unlock[i]) begin
               viol_cnt_q[i] <= '0;
               lock_q[i]     <= 1'b0;
            end else if (state_q == DROP && src_q == SRC_W'(i)) begin
               if (viol_cnt_q[i] != LCNT_W'(LOCK_THRESH))
                  viol_cnt_q[i] <= viol_cnt_q[i] + LCNT_W'(1);
               if (viol_cnt_q[i] + LCNT_W'(1) >= LCNT_W'(LOCK_THRESH))
                  lock_q[i] <= 1'b1;
            end
         end
      end
   end

   assign flt_addr    = flt_q.addr;
   assign flt_cmd     = flt_q.cmd;
   assign flt_data    = flt_q.data;
   assign out_valid   = out_valid_q;
   assign out_addr    = out_q.addr;
   assign out_cmd     = out_q.cmd;
   assign out_data    = out_q.data;
   assign out_src     = out_src_q;
   assign drop_pulse  = drop_q;
   assign lock_status = lock_q;
   assign viol_total  = total_q;

endmodule

// File: tb/tb_fw_txn_arbiter.sv
// Self-checking bench for fw_txn_arbiter with a stand-in packet filter and a
// transaction-level reference model.
module tb_fw_txn_arbiter;

   localparam int NR = 4;
   localparam int LT = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid, req_ready, lock_status, unlock;
   logic [16*NR-1:0] req_addr;
   logic [4*NR-1:0]  req_cmd;
   logic [32*NR-1:0] req_data;
   logic [15:0]      flt_addr, out_addr, viol_total;
   logic [3:0]       flt_cmd, out_cmd;
   logic [31:0]      flt_data, out_data;
   logic             flt_violation, out_valid, out_ready, drop_pulse;
   logic [1:0]       out_src;

   always #5 clk = ~clk;

   fw_txn_arbiter #(.NUM_REQ(NR), .LOCK_THRESH(LT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_cmd(req_cmd), .req_data(req_data),
      .flt_addr(flt_addr), .flt_cmd(flt_cmd), .flt_data(flt_data),
      .flt_violation(flt_violation),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_cmd(out_cmd), .out_data(out_data),
      .out_src(out_src), .drop_pulse(drop_pulse),
      .lock_status(lock_status), .unlock(unlock), .viol_total(viol_total)
   );

   // Filter rules: null address, poison data word, or cmd 2 to the 0x1234 register.
   function automatic bit rule_viol(logic [15:0] a, logic [3:0] c, logic [31:0] d);
      return (a == 16'h0000) || (d == 32'hDEADBEEF) || (c == 4'd2 && a == 16'h1234);
   endfunction

   // Stand-in packet filter: registered verdict, one cycle latency.
   always @(posedge clk or posedge rst) begin
      if (rst) flt_violation <= 1'b0;
      else     flt_violation <= rule_viol(flt_addr, flt_cmd, flt_data);
   end

   typedef struct packed {logic [15:0] addr; logic [3:0] cmd; logic [31:0] data;} tb_txn_t;
   typedef struct {int src; logic [15:0] addr; logic [3:0] cmd; logic [31:0] data;
                   bit exp_drop; int exp_total;} vec_t;

   int n_cmp = 0, n_bad = 0;

   tb_txn_t pend [NR][256];
   int      hd [NR], tl [NR];

   // Reference model state
   int            per = 0;
   bit            m_busy;
   int            m_gcyc, m_src, m_ptr, m_total;
   bit            m_viol;
   tb_txn_t       m_txn;
   int            m_cnt [NR];
   logic [NR-1:0] m_lock;

   // Stimulus controls
   bit            rand_valid, gate_valid, ov_prev;
   int            rdy_mode, rdy_hold_left;
   logic [NR-1:0] unlock_req, unlock_on_drop;

   // Observed events
   int          glog[$];
   int          ev_per, ev_gper, ev_src;
   bit          ev_drop;
   logic [15:0] ev_addr;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic enq(int r, logic [15:0] a, logic [3:0] c, logic [31:0] d);
      pend[r][tl[r] % 256] = '{a, c, d};
      tl[r]++;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < NR; i++) if (hd[i] != tl[i]) p = 1'b1;
      return p;
   endfunction

   task automatic model_clear();
      m_busy = 0; m_ptr = 0; m_total = 0; m_lock = '0; m_gcyc = 0; m_src = 0; m_viol = 0;
      for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; hd[i] = 0; tl[i] = 0; end
      ov_prev = 0; gate_valid = 0; rand_valid = 0; rdy_mode = 0; rdy_hold_left = 0;
      unlock_req = '0; unlock_on_drop = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; unlock = '0; out_ready = 1'b0;
      req_addr = '0; req_cmd = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);   chk("rst_out_valid", out_valid, 0);
      chk("rst_drop", drop_pulse, 0);       chk("rst_lock", lock_status, 0);
      chk("rst_total", viol_total, 0);      chk("rst_flt", {flt_addr, flt_cmd, flt_data}, 0);
      chk("rst_out", {out_addr, out_cmd, out_data}, 0); chk("rst_src", out_src, 0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // One clock period: drive after the rising edge, check at the falling edge, advance the model.
   task automatic step();
      int g, c;
      bit drop_now, fwd_now, has;
      logic [NR-1:0] ul;
      @(posedge clk); #1;
      drop_now = m_busy && m_viol && (per == m_gcyc + 3);
      fwd_now  = m_busy && !m_viol && (per >= m_gcyc + 3);
      for (int i = 0; i < NR; i++) begin
         has = (hd[i] != tl[i]) && !gate_valid;
         req_valid[i] = has && (!rand_valid || $urandom_range(0, 3) != 0);
         req_addr[16*i +: 16] = has ? pend[i][hd[i] % 256].addr : 16'h0;
         req_cmd[4*i +: 4]    = has ? pend[i][hd[i] % 256].cmd  : 4'h0;
         req_data[32*i +: 32] = has ? pend[i][hd[i] % 256].data : 32'h0;
      end
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            if (fwd_now && rdy_hold_left > 0) begin out_ready = 1'b0; rdy_hold_left--; end
            else out_ready = 1'b1;
         end
      endcase
      ul = unlock_req | (drop_now ? unlock_on_drop : '0);
      unlock = ul;
      unlock_req = '0;
      @(negedge clk);
      g = -1;
      if (!m_busy)
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (g < 0 && req_valid[c] && !m_lock[c]) g = c;
         end
      chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("drop_pulse", drop_pulse, drop_now);
      chk("out_valid", out_valid, fwd_now);
      chk("lock_status", lock_status, m_lock);
      chk("viol_total", viol_total, m_total);
      if (fwd_now) begin
         chk("out_addr", out_addr, m_txn.addr); chk("out_cmd", out_cmd, m_txn.cmd);
         chk("out_data", out_data, m_txn.data); chk("out_src_fwd", out_src, m_src);
      end
      if (drop_now) chk("out_src_drop", out_src, m_src);
      if (req_ready != '0) begin
         for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
         ev_gper = per;
      end
      if ((out_valid && !ov_prev) || drop_pulse) begin
         ev_per = per; ev_drop = drop_pulse; ev_src = out_src; ev_addr = out_addr;
      end
      ov_prev = out_valid;
      if (g >= 0) begin
         m_txn  = pend[g][hd[g] % 256];
         m_src  = g;
         m_viol = rule_viol(m_txn.addr, m_txn.cmd, m_txn.data);
         m_busy = 1; m_gcyc = per; m_ptr = (g + 1) % NR; hd[g]++;
      end else if (drop_now) begin
         m_busy = 0;
         if (m_total < 65535) m_total++;
         if (m_cnt[m_src] < LT) m_cnt[m_src]++;
         if (m_cnt[m_src] == LT) m_lock[m_src] = 1'b1;
      end else if (fwd_now && out_ready) begin
         m_busy = 0;
      end
      for (int i = 0; i < NR; i++) if (ul[i]) begin m_cnt[i] = 0; m_lock[i] = 1'b0; end
      per++;
   endtask

   task automatic drain(int max);
      int n = 0;
      while ((m_busy || pending()) && n < max) begin step(); n++; end
      chk("drain_done", {63'd0, !(m_busy || pending())}, 1);
      step();
   endtask

   task automatic count_grants(int r, output int n);
      n = 0;
      foreach (glog[i]) if (glog[i] == r) n++;
   endtask

   vec_t vt [6];
   int   exp_order [5];

   initial begin
      int n0, n2, n;
      do_reset();

      // Single transactions, one per table row.
      vt[0] = '{0, 16'h1000, 4'h1, 32'h0000_0001, 1'b0, 0};
      vt[1] = '{1, 16'h2000, 4'h1, 32'hDEAD_BEEF, 1'b1, 1};
      vt[2] = '{3, 16'h1234, 4'h2, 32'h0000_0005, 1'b1, 2};
      vt[3] = '{3, 16'h1234, 4'h3, 32'h0000_0005, 1'b0, 2};
      vt[4] = '{2, 16'h0000, 4'h1, 32'h0000_0001, 1'b1, 3};
      vt[5] = '{1, 16'h5555, 4'hF, 32'h1234_5678, 1'b0, 3};
      for (int v = 0; v < 6; v++) begin
         ev_per = -1; ev_gper = -1;
         enq(vt[v].src, vt[v].addr, vt[v].cmd, vt[v].data);
         drain(40);
         chk("vec_drop", ev_drop, vt[v].exp_drop);
         chk("vec_src", ev_src, vt[v].src);
         chk("vec_latency", ev_per - ev_gper, 3);
         chk("vec_total", viol_total, vt[v].exp_total);
         if (!vt[v].exp_drop) chk("vec_addr", ev_addr, vt[v].addr);
      end

      // All four requesters valid; round-robin order and stall stability.
      do_reset();
      enq(0, 16'h0100, 4'h1, 32'h10); enq(0, 16'h0104, 4'h1, 32'h14);
      enq(1, 16'h0200, 4'h1, 32'h20); enq(2, 16'h0300, 4'h1, 32'h30);
      enq(3, 16'h0400, 4'h1, 32'h40);
      rdy_mode = 2; rdy_hold_left = 5;
      glog.delete();
      drain(120);
      exp_order = '{0, 1, 2, 3, 0};
      chk("rr_count", glog.size(), 5);
      for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", glog[i], exp_order[i]);

      // Lockout after three violations, masked from arbitration, then unlock.
      do_reset();
      for (int i = 0; i < 3; i++) enq(2, 16'h0000, 4'h1, 32'h1);
      drain(60);
      chk("lock_after_3", lock_status, 4'b0100);
      chk("lock_total", viol_total, 3);
      enq(2, 16'h2222, 4'h1, 32'h22); enq(0, 16'h0100, 4'h1, 32'h1);
      glog.delete();
      repeat (30) step();
      count_grants(2, n2); count_grants(0, n0);
      chk("locked_r2_grants", n2, 0);
      chk("r0_while_r2_locked", n0, 1);
      unlock_req = 4'b0100;
      drain(40);
      chk("unlocked_status", lock_status, 0);
      count_grants(2, n2);
      chk("r2_regranted", n2, 1);

      // Unlock coinciding with a drop clears the count.
      do_reset();
      enq(1, 16'h0000, 4'h1, 32'h1); enq(1, 16'h0000, 4'h1, 32'h1);
      drain(40);
      unlock_on_drop = 4'b0010;
      enq(1, 16'h0000, 4'h1, 32'h1);
      drain(20);
      unlock_on_drop = '0;
      chk("unlock_wins", lock_status, 0);
      enq(1, 16'h0000, 4'h1, 32'h1);
      drain(20);
      chk("count_restarted", lock_status, 0);
      enq(1, 16'h0000, 4'h1, 32'h1); enq(1, 16'h0000, 4'h1, 32'h1);
      drain(40);
      chk("relock", lock_status, 4'b0010);
      chk("relock_total", viol_total, 6);

      // Asynchronous reset during EVAL.
      do_reset();
      enq(0, 16'h0000, 4'h1, 32'h1);
      drain(20);
      enq(1, 16'h3333, 4'h1, 32'h33);
      n = 0;
      while (!(m_busy && per == m_gcyc + 2) && n < 20) begin step(); n++; end
      chk("reach_eval", n < 20, 1);
      @(posedge clk); #2;
      chk("eval_flt_addr", flt_addr, 16'h3333);
      rst = 1'b1; #1;
      chk("arst_flt", {flt_addr, flt_cmd, flt_data}, 0);
      chk("arst_out", {out_valid, out_addr, out_cmd, out_data, out_src}, 0);
      chk("arst_drop", drop_pulse, 0);
      chk("arst_total", viol_total, 0);
      chk("arst_lock", lock_status, 0);
      chk("arst_ready", req_ready, 0);
      @(negedge clk); rst = 1'b0;
      model_clear();
      enq(1, 16'h4444, 4'h1, 32'h44); enq(0, 16'h5555, 4'h1, 32'h55);
      glog.delete();
      drain(40);
      chk("post_rst_first", (glog.size() > 0) ? glog[0] : -1, 0);

      // Randomized traffic against the reference model.
      do_reset();
      rand_valid = 1; rdy_mode = 1;
      for (int t = 0; t < 1500; t++) begin
         for (int r = 0; r < NR; r++)
            if (tl[r] - hd[r] < 3 && $urandom_range(0, 2) == 0) begin
               int sel = $urandom_range(0, 7);
               enq(r, (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h1234 : 16'($urandom),
                   4'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? 32'hDEADBEEF : $urandom);
            end
         if ($urandom_range(0, 39) == 0) unlock_req = 4'($urandom);
         step();
      end
      gate_valid = 1;
      n = 0;
      while (m_busy && n < 200) begin step(); n++; end
      chk("rand_settle", n < 200, 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
